// File: rtl/de2_pkg.sv
// Shared constants for the DE2 accumulator: seven-segment glyphs (active low,
// bit0 = seg a) and the button debounce defaults.
package de2_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int DEB_CNT_W           = $clog2(DEBOUNCE_CYCLES_DEF + 1);

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic logic [6:0] hex_to_seg(logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_0;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button path: invert, 2-FF synchronise, debounce the level and emit a
// single-cycle pulse when the accepted level becomes "pressed".
module button_debounce
  import de2_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample;
  // a pulse is raised only when that flip goes released -> pressed.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        pulse_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed     = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/de2_wrapper.sv
// DE2 top: KEY0 loads SW into the operand, KEY1 adds the operand into a 16-bit
// accumulator; LEDR mirrors the operand and HEX3..HEX0 show the accumulator.
module de2_wrapper
  import de2_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic        CLOCK_50,
  input  logic [2:0]  KEY,
  input  logic [15:0] SW,
  output logic [15:0] LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  logic        clk;
  logic        rst_q;
  logic [1:0]  press_pulse;
  logic [1:0]  unused_pressed;
  logic [15:0] operand_q, operand_d;
  logic [15:0] acc_q, acc_d;
  logic [27:0] hex_q, hex_d;

  assign clk = CLOCK_50;

  // The reset pin is registered once; it has no reset of its own.
  always_ff @(posedge clk) begin
    rst_q <= ~KEY[2];
  end

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
    .clk         (clk),
    .rst         (rst_q),
    .btn_n       (KEY[0]),
    .pressed     (unused_pressed[0]),
    .press_pulse (press_pulse[0])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
    .clk         (clk),
    .rst         (rst_q),
    .btn_n       (KEY[1]),
    .pressed     (unused_pressed[1]),
    .press_pulse (press_pulse[1])
  );

  // Simultaneous presses: the add uses the operand held before this edge.
  always_comb begin
    operand_d = operand_q;
    acc_d     = acc_q;
    if (press_pulse[0]) operand_d = SW;
    if (press_pulse[1]) acc_d = acc_q + operand_q;
    hex_d = {hex_to_seg(acc_q[15:12]), hex_to_seg(acc_q[11:8]),
             hex_to_seg(acc_q[7:4]),   hex_to_seg(acc_q[3:0])};
  end

  always_ff @(posedge clk) begin
    if (rst_q) begin
      operand_q <= '0;
      acc_q     <= '0;
      hex_q     <= {4{SEG_0}};
    end else begin
      operand_q <= operand_d;
      acc_q     <= acc_d;
      hex_q     <= hex_d;
    end
  end

  assign LEDR = operand_q;
  assign HEX3 = hex_q[27:21];
  assign HEX2 = hex_q[20:14];
  assign HEX1 = hex_q[13:7];
  assign HEX0 = hex_q[6:0];

endmodule

// File: tb/tb_de2_wrapper.sv
// Directed bench for de2_wrapper: reset, accumulation, debounce timing, wrap,
// simultaneous presses and reset while a button is held.
module tb_de2_wrapper;

  localparam int DB = 16;

  logic        clk = 1'b0;
  logic [2:0]  key;
  logic [15:0] sw;
  logic [15:0] ledr;
  logic [6:0]  hex0, hex1, hex2, hex3;
  int          total = 0;
  int          bad   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #10 clk = ~clk;

  de2_wrapper #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .SW       (sw),
    .LEDR     (ledr),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3)
  );

  function automatic logic [27:0] exp_hex(input logic [15:0] acc);
    return {seg_tab[acc[15:12]], seg_tab[acc[11:8]], seg_tab[acc[7:4]], seg_tab[acc[3:0]]};
  endfunction

  task automatic settle();
    repeat (DB + 8) @(negedge clk);
  endtask

  // m bit set = press that button; all inputs change on the falling edge.
  task automatic press(input logic [1:0] m, input int hold);
    @(negedge clk);
    key[1:0] = ~m;
    repeat (hold) @(negedge clk);
    key[1:0] = 2'b11;
    settle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    key = 3'b011;
    repeat (4) @(negedge clk);
    key[2] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    sw  = 16'h0001;
    key = 3'b011;
    repeat (3) @(negedge clk);
    key[1:0] = 2'b00;
    repeat (30) @(negedge clk);
    key[1:0] = 2'b11;
    repeat (3) @(negedge clk);
    total++;
    if (ledr !== 16'h0000) begin bad++; $display("FAIL reset_ledr got=%h want=0000", ledr); end
    total++;
    if ({hex3, hex2, hex1, hex0} !== {4{7'h40}}) begin
      bad++; $display("FAIL reset_hex got=%h %h %h %h want=40 40 40 40", hex3, hex2, hex1, hex0);
    end
    key[2] = 1'b1;
    settle();
    total++;
    if (ledr !== 16'h0000) begin bad++; $display("FAIL reset_exit_ledr got=%h want=0000", ledr); end
    total++;
    if ({hex3, hex2, hex1, hex0} !== {4{7'h40}}) begin
      bad++; $display("FAIL reset_exit_hex got=%h %h %h %h want=40 40 40 40", hex3, hex2, hex1, hex0);
    end
  endtask

  task automatic test_accumulate();
    int          sw_seq  [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 15, 12};
    logic [15:0] acc_exp [11] = '{16'h0000, 16'h0001, 16'h0003, 16'h0006, 16'h000A, 16'h000F,
                                  16'h0015, 16'h001C, 16'h0024, 16'h0033, 16'h003F};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      sw = 16'(sw_seq[i]);
      press(2'b01, 50);
      press(2'b10, 50);
      total++;
      if (ledr !== 16'(sw_seq[i])) begin
        bad++; $display("FAIL accum_ledr step=%0d got=%h want=%h", i, ledr, 16'(sw_seq[i]));
      end
      total++;
      if ({hex3, hex2, hex1, hex0} !== exp_hex(acc_exp[i])) begin
        bad++; $display("FAIL accum_hex step=%0d got=%h %h %h %h want acc=%h", i, hex3, hex2, hex1, hex0, acc_exp[i]);
      end
    end
    total++;
    if (hex1 !== 7'h30 || hex0 !== 7'h0E) begin
      bad++; $display("FAIL accum_final got=%h %h want=30 0e", hex1, hex0);
    end
  endtask

  task automatic test_latency();
    do_reset();
    @(negedge clk);
    sw     = 16'hA5C3;
    key[0] = 1'b0;
    repeat (DB + 2) @(posedge clk);
    @(negedge clk);
    total++;
    if (ledr !== 16'h0000) begin bad++; $display("FAIL lat_ledr_early got=%h want=0000", ledr); end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ledr !== 16'hA5C3) begin bad++; $display("FAIL lat_ledr_edge got=%h want=a5c3", ledr); end
    key[0] = 1'b1;
    settle();
    @(negedge clk);
    key[1] = 1'b0;
    repeat (DB + 3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({hex3, hex2, hex1, hex0} !== {4{7'h40}}) begin
      bad++; $display("FAIL lat_hex_early got=%h %h %h %h want=40 40 40 40", hex3, hex2, hex1, hex0);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({hex3, hex2, hex1, hex0} !== {7'h08, 7'h12, 7'h46, 7'h30}) begin
      bad++; $display("FAIL lat_hex_edge got=%h %h %h %h want=08 12 46 30", hex3, hex2, hex1, hex0);
    end
    key[1] = 1'b1;
    settle();
  endtask

  task automatic test_glitch();
    do_reset();
    sw = 16'h00C7;
    press(2'b01, DB - 1);
    total++;
    if (ledr !== 16'h0000) begin bad++; $display("FAIL glitch_short got=%h want=0000", ledr); end
    press(2'b01, DB);
    total++;
    if (ledr !== 16'h00C7) begin bad++; $display("FAIL glitch_exact got=%h want=00c7", ledr); end
  endtask

  task automatic test_hold_single();
    do_reset();
    sw = 16'h1234;
    @(negedge clk);
    key[0] = 1'b0;
    repeat (60) @(negedge clk);
    sw = 16'h4321;
    repeat (140) @(negedge clk);
    total++;
    if (ledr !== 16'h1234) begin bad++; $display("FAIL hold_key0 got=%h want=1234", ledr); end
    key[0] = 1'b1;
    settle();
    press(2'b10, 200);
    total++;
    if ({hex3, hex2, hex1, hex0} !== exp_hex(16'h1234)) begin
      bad++; $display("FAIL hold_key1 got=%h %h %h %h want acc=1234", hex3, hex2, hex1, hex0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sw = 16'h0002;
    press(2'b01, 50);
    press(2'b10, 50);
    sw = 16'hFFFF;
    press(2'b01, 50);
    press(2'b10, 50);
    total++;
    if ({hex3, hex2, hex1, hex0} !== {7'h40, 7'h40, 7'h40, 7'h79}) begin
      bad++; $display("FAIL wrap got=%h %h %h %h want=40 40 40 79", hex3, hex2, hex1, hex0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    sw = 16'h0005;
    press(2'b01, 50);
    sw = 16'h0009;
    press(2'b11, 50);
    total++;
    if (ledr !== 16'h0009) begin bad++; $display("FAIL simul_ledr got=%h want=0009", ledr); end
    total++;
    if ({hex3, hex2, hex1, hex0} !== exp_hex(16'h0005)) begin
      bad++; $display("FAIL simul_acc got=%h %h %h %h want acc=0005", hex3, hex2, hex1, hex0);
    end
  endtask

  task automatic test_reset_mid_press();
    do_reset();
    sw = 16'h0024;
    press(2'b01, 50);
    press(2'b10, 50);
    total++;
    if ({hex3, hex2, hex1, hex0} !== exp_hex(16'h0024)) begin
      bad++; $display("FAIL rmid_setup got=%h %h %h %h want acc=0024", hex3, hex2, hex1, hex0);
    end
    @(negedge clk);
    key[1] = 1'b0;
    repeat (10) @(negedge clk);
    key[2] = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if ({hex3, hex2, hex1, hex0} !== {4{7'h40}} || ledr !== 16'h0000) begin
      bad++; $display("FAIL rmid_in_reset got=%h %h %h %h ledr=%h want=40 40 40 40 ledr=0000", hex3, hex2, hex1, hex0, ledr);
    end
    key[2] = 1'b1;
    repeat (DB + 10) @(negedge clk);
    key[1] = 1'b1;
    settle();
    total++;
    if ({hex3, hex2, hex1, hex0} !== {4{7'h40}} || ledr !== 16'h0000) begin
      bad++; $display("FAIL rmid_after got=%h %h %h %h ledr=%h want=40 40 40 40 ledr=0000", hex3, hex2, hex1, hex0, ledr);
    end
  endtask

  initial begin
    key = 3'b011;
    sw  = '0;
    test_reset();
    test_accumulate();
    test_latency();
    test_glitch();
    test_hold_single();
    test_wrap();
    test_simultaneous();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
